fft_bfly_sched: RTL and testbench
=================================

Name: fft_bfly_sched

Overview:
- Sequencer for an in-place radix-2 DIT FFT held in the 1024x32 dual-port data RAM.
- Each butterfly: reads the operand pair through RAM ports A and B, hands the pair and its twiddle index to the CORDIC butterfly, then writes both results back to the same addresses.
- Sits between the FFT top-level control and the data RAM / CORDIC butterfly datapath.
- Input samples are already in the RAM in bit-reversed order; output is in natural order.

Parameters:
- N_LOG2, 10, log2 of FFT length (N = 2**N_LOG2); legal range 2..10.
- DATA_W, 32, complex sample width: {re[31:16], im[15:0]}, two's complement.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- o_busy  out  1  high from the cycle after start is accepted until DONE.
- o_done  out  1  one-cycle pulse after the final write-back.
- o_stage  out  4  current stage index s.
- o_addr_a  out  N_LOG2  RAM port A address.
- o_addr_b  out  N_LOG2  RAM port B address.
- o_we_a  out  1  RAM port A write enable.
- o_we_b  out  1  RAM port B write enable.
- o_wdata_a  out  DATA_W  RAM port A write data.
- o_wdata_b  out  DATA_W  RAM port B write data.
- i_rdata_a  in  DATA_W  RAM port A read data (registered, 1-cycle latency).
- i_rdata_b  in  DATA_W  RAM port B read data (registered, 1-cycle latency).
- o_bf_valid  out  1  operand-valid strobe to the butterfly.
- o_bf_a  out  DATA_W  operand A to the butterfly.
- o_bf_b  out  DATA_W  operand B to the butterfly.
- o_tw_idx  out  N_LOG2-1  twiddle index k (angle = -2*pi*k/N).
- i_bf_valid  in  1  result-valid strobe from the butterfly.
- i_bf_x  in  DATA_W  butterfly result destined for the A address.
- i_bf_y  in  DATA_W  butterfly result destined for the B address.

Behaviour:
- Reset: state IDLE, all counters 0, every output 0.
- Reset asserted mid-run aborts immediately; RAM contents are left partially processed; no o_done is produced.
- Counters: stage s = 0..N_LOG2-1; butterfly j = 0..N/2-1.
- Address generation, with half = 1<<s, pos = j & (half-1), grp = j >> s:
  - addr_a = (grp << (s+1)) | pos
  - addr_b = addr_a + half
  - tw_idx = pos << (N_LOG2-1-s)
- FSM states IDLE, READ, ISSUE, WAIT_BF, WRITE, DONE:
  - IDLE: i_start=1 -> READ, with s=0 and j=0.
  - READ (1 cycle): drive addr_a/addr_b with we=0 -> ISSUE.
  - ISSUE (1 cycle): o_bf_valid=1; o_bf_a/o_bf_b = i_rdata_a/i_rdata_b; o_tw_idx valid -> WAIT_BF.
  - WAIT_BF: hold addresses and o_tw_idx. On i_bf_valid, register i_bf_x/i_bf_y -> WRITE. No timeout.
  - WRITE (1 cycle): o_we_a = o_we_b = 1; wdata = registered results; same addresses as READ. Then advance:
    - j < N/2-1: j++ -> READ.
    - j = N/2-1 and s < N_LOG2-1: j=0, s++ -> READ.
    - j = N/2-1 and s = N_LOG2-1: -> DONE.
  - DONE (1 cycle): o_done=1, o_busy=0 -> IDLE.
- Butterfly handshake:
  - i_bf_valid is ignored in every state except WAIT_BF, including the ISSUE cycle itself.
  - One butterfly is in flight at a time.
- i_start while busy is ignored.
- Addresses and we are 0 in IDLE and DONE.
- Ports A and B never write the same address; the write-before-next-read ordering makes RAM collisions impossible by construction.
- Cycles per butterfly = 3 + L, where L >= 1 is the butterfly response delay measured in cycles after ISSUE.
- Run length = (N/2)*N_LOG2*(3+L) + 1 cycles, from the first READ through DONE.

Decomposition:
- Package fft_pkg:
  - typedef of the FSM state enum.
  - DATA_W constant.
  - complex pack/unpack field positions (RE_MSB=31, RE_LSB=16, IM_MSB=15, IM_LSB=0).
- Sub-module fft_addr_calc: combinational (s, j) -> addr_a, addr_b, tw_idx, reused by the twiddle ROM addressing.

Test Plan:
- N_LOG2=3, butterfly model with L=1 -> 12 butterflies, 4 cycles each.
  - Stage 0: (0,1),(2,3),(4,5),(6,7), tw 0.
  - Stage 1: (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
  - Stage 2: (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
  - o_done pulses exactly 49 cycles after the first READ.
- N_LOG2=3, RAM preloaded with word = address, model returns x=a+b, y=a-b -> final RAM matches the golden in-place DIT model with unit twiddles; o_bf_a/o_bf_b equal the preloaded words in stage 0.
- Random L in 1..20 with spurious i_bf_valid pulses in READ and ISSUE -> stray pulses ignored, address sequence unchanged, total cycles equal the sum over butterflies of (3+L).
- i_start pulsed during stage 1 -> no restart, sequence and o_done timing unchanged; i_start in IDLE after DONE -> new run starts at s=0, j=0.
- i_rst_n low while in WAIT_BF of stage 1 -> all outputs 0 asynchronously, o_done never pulses; a subsequent i_start runs the full sequence.
- N_LOG2=10, L=1 -> 5120 butterflies; last pair (511,1023) with tw 511; o_done at cycle 20481.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and constants for the in-place radix-2 FFT sequencer
package fft_pkg;

    localparam int DATA_W = 32;

    localparam int RE_MSB = 31;
    localparam int RE_LSB = 16;
    localparam int IM_MSB = 15;
    localparam int IM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_ISSUE,
        ST_WAIT_BF,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] cplx_pack(
        input logic [RE_MSB-RE_LSB:0] re,
        input logic [IM_MSB-IM_LSB:0] im
    );
        return {re, im};
    endfunction

endpackage

// File: rtl/fft_bfly_sched_if.sv
// rtl/fft_bfly_sched_if.sv - data RAM and butterfly datapath signals of the FFT sequencer
interface fft_bfly_sched_if #(
    parameter int N_LOG2 = 10,
    parameter int DATA_W = 32
);
    logic [N_LOG2-1:0] o_addr_a;
    logic [N_LOG2-1:0] o_addr_b;
    logic              o_we_a;
    logic              o_we_b;
    logic [DATA_W-1:0] o_wdata_a;
    logic [DATA_W-1:0] o_wdata_b;
    logic [DATA_W-1:0] i_rdata_a;
    logic [DATA_W-1:0] i_rdata_b;
    logic              o_bf_valid;
    logic [DATA_W-1:0] o_bf_a;
    logic [DATA_W-1:0] o_bf_b;
    logic [N_LOG2-2:0] o_tw_idx;
    logic              i_bf_valid;
    logic [DATA_W-1:0] i_bf_x;
    logic [DATA_W-1:0] i_bf_y;

    modport master (
        output o_addr_a, o_addr_b, o_we_a, o_we_b, o_wdata_a, o_wdata_b,
        output o_bf_valid, o_bf_a, o_bf_b, o_tw_idx,
        input  i_rdata_a, i_rdata_b, i_bf_valid, i_bf_x, i_bf_y
    );

    modport slave (
        input  o_addr_a, o_addr_b, o_we_a, o_we_b, o_wdata_a, o_wdata_b,
        input  o_bf_valid, o_bf_a, o_bf_b, o_tw_idx,
        output i_rdata_a, i_rdata_b, i_bf_valid, i_bf_x, i_bf_y
    );
endinterface

// File: rtl/fft_addr_calc.sv
// rtl/fft_addr_calc.sv - (stage, butterfly) to operand addresses and twiddle index
module fft_addr_calc #(
    parameter int N_LOG2 = 10
) (
    input  logic [3:0]        stage,
    input  logic [N_LOG2-2:0] bfly,
    output logic [N_LOG2-1:0] addr_a,
    output logic [N_LOG2-1:0] addr_b,
    output logic [N_LOG2-2:0] tw_idx
);
    localparam logic [N_LOG2-1:0] ONE = N_LOG2'(1);
    localparam logic [3:0]        TW_TOP = 4'(N_LOG2 - 1);

    logic [N_LOG2-1:0] bfly_ext;
    logic [N_LOG2-1:0] half;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] grp;
    logic [3:0]        tw_sh;

    always_comb begin
        bfly_ext = {1'b0, bfly};
        half     = ONE << stage;
        pos      = bfly_ext & (half - ONE);
        grp      = bfly_ext >> stage;
        // Each group spans 2*half words: A in the lower half, B in the upper half.
        addr_a   = (grp << (stage + 4'd1)) | pos;
        addr_b   = addr_a + half;
        tw_sh    = TW_TOP - stage;
        tw_idx   = pos[N_LOG2-2:0] << tw_sh;
    end
endmodule

// File: rtl/fft_bfly_sched.sv
// rtl/fft_bfly_sched.sv - in-place radix-2 DIT FFT butterfly sequencer
module fft_bfly_sched #(
    parameter int N_LOG2 = 10,
    parameter int DATA_W = fft_pkg::DATA_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_stage,
    fft_bfly_sched_if.master bus
);
    import fft_pkg::*;

    localparam logic [N_LOG2-2:0] J_LAST = '1;
    localparam logic [N_LOG2-2:0] J_ONE  = (N_LOG2-1)'(1);
    localparam logic [3:0]        S_LAST = 4'(N_LOG2 - 1);

    state_t            state_q, state_d;
    logic [3:0]        s_q, s_d;
    logic [N_LOG2-2:0] j_q, j_d;
    logic [DATA_W-1:0] x_q, y_q;
    logic [N_LOG2-1:0] calc_a, calc_b;
    logic [N_LOG2-2:0] calc_tw;
    logic              active;

    fft_addr_calc #(.N_LOG2(N_LOG2)) u_addr_calc (
        .stage  (s_q),
        .bfly   (j_q),
        .addr_a (calc_a),
        .addr_b (calc_b),
        .tw_idx (calc_tw)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            j_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            if (state_q == ST_WAIT_BF && bus.i_bf_valid) begin
                x_q <= bus.i_bf_x;
                y_q <= bus.i_bf_y;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_READ;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            ST_READ:    state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT_BF;
            ST_WAIT_BF: if (bus.i_bf_valid) state_d = ST_WRITE;
            ST_WRITE: begin
                state_d = ST_READ;
                if (j_q != J_LAST) begin
                    j_d = j_q + J_ONE;
                end else if (s_q != S_LAST) begin
                    j_d = '0;
                    s_d = s_q + 4'd1;
                end else begin
                    // Counters drop back to zero so the stage output reads 0 once finished.
                    state_d = ST_DONE;
                    j_d     = '0;
                    s_d     = '0;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign active  = (state_q == ST_READ) || (state_q == ST_ISSUE) ||
                     (state_q == ST_WAIT_BF) || (state_q == ST_WRITE);
    assign o_busy  = active;
    assign o_done  = (state_q == ST_DONE);
    assign o_stage = s_q;

    always_comb begin
        bus.o_addr_a   = '0;
        bus.o_addr_b   = '0;
        bus.o_tw_idx   = '0;
        bus.o_we_a     = 1'b0;
        bus.o_we_b     = 1'b0;
        bus.o_wdata_a  = '0;
        bus.o_wdata_b  = '0;
        bus.o_bf_valid = 1'b0;
        bus.o_bf_a     = '0;
        bus.o_bf_b     = '0;
        if (active) begin
            bus.o_addr_a = calc_a;
            bus.o_addr_b = calc_b;
            bus.o_tw_idx = calc_tw;
        end
        if (state_q == ST_ISSUE) begin
            bus.o_bf_valid = 1'b1;
            bus.o_bf_a     = bus.i_rdata_a;
            bus.o_bf_b     = bus.i_rdata_b;
        end
        if (state_q == ST_WRITE) begin
            bus.o_we_a    = 1'b1;
            bus.o_we_b    = 1'b1;
            bus.o_wdata_a = x_q;
            bus.o_wdata_b = y_q;
        end
    end
endmodule

// File: tb/tb_fft_bfly_sched.sv
// tb/tb_fft_bfly_sched.sv - self-checking bench for fft_bfly_sched (N_LOG2=3 and N_LOG2=10)
module tb_fft_bfly_sched;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start3 = 1'b0;
    logic       start10 = 1'b0;
    logic       busy3, done3, busy10, done10;
    logic [3:0] stage3, stage10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_bfly_sched_if #(.N_LOG2(3),  .DATA_W(DW)) bus3 ();
    fft_bfly_sched_if #(.N_LOG2(10), .DATA_W(DW)) bus10 ();

    fft_bfly_sched #(.N_LOG2(3), .DATA_W(DW)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3),
        .o_busy(busy3), .o_done(done3), .o_stage(stage3), .bus(bus3)
    );

    fft_bfly_sched #(.N_LOG2(10), .DATA_W(DW)) dut10 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start10),
        .o_busy(busy10), .o_done(done10), .o_stage(stage10), .bus(bus10)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cadd(input logic [31:0] p, input logic [31:0] q);
        logic [15:0] re, im;
        re = p[31:16] + q[31:16];
        im = p[15:0] + q[15:0];
        return {re, im};
    endfunction

    function automatic logic [31:0] csub(input logic [31:0] p, input logic [31:0] q);
        logic [15:0] re, im;
        re = p[31:16] - q[31:16];
        im = p[15:0] - q[15:0];
        return {re, im};
    endfunction

    // 8-word data RAM with registered reads
    logic [DW-1:0] mem [8];
    logic          preload = 1'b0;
    always @(posedge clk) begin
        bus3.i_rdata_a <= mem[bus3.o_addr_a];
        bus3.i_rdata_b <= mem[bus3.o_addr_b];
        if (preload) begin
            for (int i = 0; i < 8; i++) mem[i] <= DW'(i);
        end else begin
            if (bus3.o_we_a) mem[bus3.o_addr_a] <= bus3.o_wdata_a;
            if (bus3.o_we_b) mem[bus3.o_addr_b] <= bus3.o_wdata_b;
        end
    end

    assign bus10.i_rdata_a = '0;
    assign bus10.i_rdata_b = '0;

    // Butterfly model for the small DUT: log each issue, answer x=a+b, y=a-b after L cycles
    int          cfg_lat = 1;
    bit          cfg_spur = 1'b0;
    bit          resp_busy = 1'b0;
    int          q_a[$], q_b[$], q_tw[$], q_lat[$], q_stage[$];
    logic [31:0] q_opa[$], q_opb[$];

    initial begin
        int          lat;
        logic [31:0] a, b;
        bus3.i_bf_valid = 1'b0;
        bus3.i_bf_x = '0;
        bus3.i_bf_y = '0;
        forever begin
            @(negedge clk);
            if (bus3.o_bf_valid === 1'b1) begin
                resp_busy = 1'b1;
                lat = (cfg_lat == 0) ? int'($urandom_range(20, 1)) : cfg_lat;
                a = bus3.o_bf_a;
                b = bus3.o_bf_b;
                q_a.push_back(int'(bus3.o_addr_a));
                q_b.push_back(int'(bus3.o_addr_b));
                q_tw.push_back(int'(bus3.o_tw_idx));
                q_stage.push_back(int'(stage3));
                q_opa.push_back(a);
                q_opb.push_back(b);
                q_lat.push_back(lat);
                if (cfg_spur) begin
                    bus3.i_bf_valid = 1'b1;
                    bus3.i_bf_x = $urandom;
                    bus3.i_bf_y = $urandom;
                end
                @(posedge clk); #1;
                bus3.i_bf_valid = 1'b0;
                repeat (lat - 1) begin @(posedge clk); #1; end
                bus3.i_bf_valid = 1'b1;
                bus3.i_bf_x = cadd(a, b);
                bus3.i_bf_y = csub(a, b);
                @(posedge clk); #1;
                bus3.i_bf_valid = 1'b0;
                if (cfg_spur) begin
                    @(posedge clk); #1;
                    bus3.i_bf_valid = 1'b1;
                    bus3.i_bf_x = $urandom;
                    bus3.i_bf_y = $urandom;
                    @(posedge clk); #1;
                    bus3.i_bf_valid = 1'b0;
                end
                resp_busy = 1'b0;
            end
        end
    end

    // Butterfly model for the large DUT: fixed L=1
    int big_cnt = 0;
    int big_a = 0, big_b = 0, big_tw = 0;
    initial begin
        bus10.i_bf_valid = 1'b0;
        bus10.i_bf_x = '0;
        bus10.i_bf_y = '0;
        forever begin
            @(negedge clk);
            if (bus10.o_bf_valid === 1'b1) begin
                big_cnt++;
                big_a = int'(bus10.o_addr_a);
                big_b = int'(bus10.o_addr_b);
                big_tw = int'(bus10.o_tw_idx);
                @(posedge clk); #1;
                bus10.i_bf_valid = 1'b1;
                @(posedge clk); #1;
                bus10.i_bf_valid = 1'b0;
            end
        end
    end

    task automatic run_small(input int lat, input bit spur, input bit mid_start, input string tag);
        int          n, exp_len, nb, ia, ib, tw, half, w;
        logic [31:0] g [8];
        logic [31:0] ea, eb;
        w = 0;
        while (resp_busy && w < 100) begin @(negedge clk); w++; end
        q_a.delete(); q_b.delete(); q_tw.delete(); q_lat.delete();
        q_stage.delete(); q_opa.delete(); q_opb.delete();
        cfg_lat = lat;
        cfg_spur = spur;
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
        for (int i = 0; i < 8; i++) g[i] = 32'(i);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk({tag, "/busy_on"}, busy3, 1);
        n = 1;
        while (done3 !== 1'b1 && n < 3000) begin
            start3 = mid_start && (stage3 == 4'd1);
            @(negedge clk);
            n++;
        end
        start3 = 1'b0;
        chk({tag, "/done"}, done3, 1);
        chk({tag, "/busy_at_done"}, busy3, 0);
        chk({tag, "/bus_at_done"}, {bus3.o_addr_a, bus3.o_addr_b, bus3.o_we_a, bus3.o_we_b}, 0);
        // Reference: every butterfly in stage/group/position order, applied to an in-place array
        nb = 0;
        exp_len = 0;
        half = 1;
        for (int s = 0; s < 3; s++) begin
            for (int grp = 0; grp < 8 / (2 * half); grp++) begin
                for (int pos = 0; pos < half; pos++) begin
                    ia = grp * 2 * half + pos;
                    ib = ia + half;
                    tw = pos * (8 / (2 * half));
                    if (nb < q_a.size()) begin
                        chk($sformatf("%s/addr_a[%0d]", tag, nb), q_a[nb], ia);
                        chk($sformatf("%s/addr_b[%0d]", tag, nb), q_b[nb], ib);
                        chk($sformatf("%s/tw[%0d]", tag, nb), q_tw[nb], tw);
                        chk($sformatf("%s/stage[%0d]", tag, nb), q_stage[nb], s);
                        chk($sformatf("%s/op_a[%0d]", tag, nb), q_opa[nb], g[ia]);
                        chk($sformatf("%s/op_b[%0d]", tag, nb), q_opb[nb], g[ib]);
                        exp_len += 3 + q_lat[nb];
                    end
                    ea = g[ia];
                    eb = g[ib];
                    g[ia] = cadd(ea, eb);
                    g[ib] = csub(ea, eb);
                    nb++;
                end
            end
            half *= 2;
        end
        chk({tag, "/bfly_count"}, q_a.size(), 12);
        chk({tag, "/run_len"}, n, exp_len + 1);
        for (int i = 0; i < 8; i++) chk($sformatf("%s/ram[%0d]", tag, i), mem[i], g[i]);
        @(negedge clk);
        chk({tag, "/idle_busy"}, busy3, 0);
        chk({tag, "/idle_done"}, done3, 0);
    endtask

    initial begin
        int n;
        bit saw_done;
        repeat (2) @(negedge clk);
        chk("rst/busy", busy3, 0);
        chk("rst/done", done3, 0);
        chk("rst/stage", stage3, 0);
        chk("rst/addr", {bus3.o_addr_a, bus3.o_addr_b}, 0);
        chk("rst/we", {bus3.o_we_a, bus3.o_we_b}, 0);
        chk("rst/bf", {bus3.o_bf_valid, bus3.o_tw_idx}, 0);
        chk("rst/bf_ops", {bus3.o_bf_a, bus3.o_bf_b}, 0);
        chk("rst/wdata", {bus3.o_wdata_a, bus3.o_wdata_b}, 0);
        chk("rst/big_busy", busy10, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_small(1, 1'b0, 1'b0, "l1");
        run_small(0, 1'b1, 1'b0, "rnd_spur");
        run_small(3, 1'b0, 1'b1, "mid_start");
        run_small(1, 1'b0, 1'b0, "restart");

        // Abort in WAIT_BF of stage 1
        cfg_lat = 10;
        cfg_spur = 1'b0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (!(stage3 == 4'd1 && bus3.o_bf_valid === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort/reach_stage1", stage3, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort/busy", busy3, 0);
        chk("abort/stage", stage3, 0);
        chk("abort/addr", {bus3.o_addr_a, bus3.o_addr_b}, 0);
        chk("abort/tw", bus3.o_tw_idx, 0);
        chk("abort/we", {bus3.o_we_a, bus3.o_we_b, bus3.o_bf_valid}, 0);
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done3 === 1'b1) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done3 === 1'b1) saw_done = 1'b1;
        end
        chk("abort/no_done", saw_done, 0);
        run_small(2, 1'b0, 1'b0, "after_abort");

        // Full-size transform
        start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0;
        n = 1;
        while (done10 !== 1'b1 && n < 25000) begin
            @(negedge clk);
            n++;
        end
        chk("big/done", done10, 1);
        chk("big/run_len", n, 20481);
        chk("big/bfly_count", big_cnt, 5120);
        chk("big/last_a", big_a, 511);
        chk("big/last_b", big_b, 1023);
        chk("big/last_tw", big_tw, 511);
        @(negedge clk);
        chk("big/idle_busy", busy10, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
